// File: rtl/code_convert_pkg.sv
// Shared definitions for the code conversion pipeline: mode encodings and
// the one-hot width derivation used by every module in the slice.
package code_convert_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BIN2OH   = 2'd0,
    MODE_OH2BIN   = 2'd1,
    MODE_BIN2GRAY = 2'd2,
    MODE_GRAY2BIN = 2'd3
  } code_mode_e;

  // One-hot width for a given binary index width.
  function automatic int oh_width(input int bin_w);
    return 1 << bin_w;
  endfunction

endpackage

// File: rtl/code_convert_comb.sv
// Purely combinational converter: one transaction's mode and data in,
// converted result and invalid-one-hot flag out. No state.
module code_convert_comb
  import code_convert_pkg::*;
#(
  parameter  int BIN_W = 4,
  localparam int OH_W  = oh_width(BIN_W)
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [OH_W-1:0]   data,
  output logic [OH_W-1:0]   result,
  output logic              err
);

  logic [BIN_W-1:0] bin;
  logic [BIN_W-1:0] oh_idx;
  logic [BIN_W-1:0] gray_enc;
  logic [BIN_W-1:0] gray_dec;
  logic             oh_ok;

  // Binary and Gray modes only look at the low BIN_W bits.
  assign bin = data[BIN_W-1:0];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign oh_ok = (data != '0) && ((data & (data - OH_W'(1))) == '0);

  // Index of the lowest set bit; scanning downward lets the lowest win.
  // All-zero input falls through to index 0.
  always_comb begin
    oh_idx = '0;
    for (int i = OH_W - 1; i >= 0; i--) begin
      if (data[i]) oh_idx = BIN_W'(i);
    end
  end

  // Gray encode is a single shift-xor.
  assign gray_enc = bin ^ (bin >> 1);

  // Gray decode: each binary bit is the running xor of Gray bits from the MSB down.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    gray_dec = '0;
    for (int i = BIN_W - 1; i >= 0; i--) begin
      acc         = acc ^ bin[i];
      gray_dec[i] = acc;
    end
  end

  // Mode select; upper result bits stay zero for the narrow-result modes.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (code_mode_e'(mode))
      MODE_BIN2OH:   result = OH_W'(1) << bin;
      MODE_OH2BIN: begin
        result[BIN_W-1:0] = oh_idx;
        err               = !oh_ok;
      end
      MODE_BIN2GRAY: result[BIN_W-1:0] = gray_enc;
      MODE_GRAY2BIN: result[BIN_W-1:0] = gray_dec;
      default: begin
        result = '0;
        err    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/code_convert_pipe.sv
// Two-stage valid/ready code conversion pipeline. Stage A captures the raw
// request, the combinational converter sits between A and B, stage B holds
// the registered result. Full backpressure, no skid buffer: in_ready is a
// combinational function of out_ready. A saturating counter tracks errored
// results as they are consumed.
module code_convert_pipe
  import code_convert_pkg::*;
#(
  parameter  int BIN_W = 4,
  parameter  int CNT_W = 8,
  localparam int OH_W  = oh_width(BIN_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [OH_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OH_W-1:0]   out_data,
  output logic [1:0]        out_mode,
  output logic              out_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [OH_W-1:0]   data;
  } req_t;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [OH_W-1:0]   data;
    logic              err;
  } rsp_t;

  // vld_pipe[1] = stage A full, vld_pipe[2] = stage B full.
  logic [STAGES:1]   vld_pipe;
  req_t              req_q;
  rsp_t              rsp_q;
  logic [OH_W-1:0]   conv_data;
  logic              conv_err;
  logic [CNT_W-1:0]  err_cnt_q;
  logic              b_load;
  logic              in_fire;
  logic              out_fire;

  // B can take a new value when empty or being drained this cycle;
  // A can take a new value when empty or moving into B.
  assign b_load   = !vld_pipe[2] || out_ready;
  assign in_ready = !vld_pipe[1] || b_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_pipe[2] && out_ready;

  // Stage A: capture request on handshake; drain when B loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      req_q       <= '0;
    end else if (in_fire) begin
      vld_pipe[1] <= 1'b1;
      req_q.mode  <= in_mode;
      req_q.data  <= in_data;
    end else if (b_load) begin
      vld_pipe[1] <= 1'b0;
    end
  end

  code_convert_comb #(
    .BIN_W (BIN_W)
  ) u_conv (
    .mode   (req_q.mode),
    .data   (req_q.data),
    .result (conv_data),
    .err    (conv_err)
  );

  // Stage B: take A's converted result; payload only updates when A is full
  // so a stalled or emptied output never changes its last data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      rsp_q       <= '0;
    end else if (b_load) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        rsp_q.mode <= req_q.mode;
        rsp_q.data <= conv_data;
        rsp_q.err  <= conv_err;
      end
    end
  end

  // Error counter: clear beats increment, increment saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (clr_cnt) begin
      err_cnt_q <= '0;
    end else if (out_fire && rsp_q.err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_data  = rsp_q.data;
  assign out_mode  = rsp_q.mode;
  assign out_err   = rsp_q.err;
  assign err_cnt   = err_cnt_q;

endmodule
